// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_if
// Purpose  : Bus bundle for the scoreboarded register file: read ports,
//            two write ports, reserve port, flush and busy status.
// Ports    : master - drives addresses/writes/reserve/flush, sees read data
//                     and busy status.
//            slave  - the register file side of the same signals.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int c_AW = $clog2(NREGS);

    logic [NRD*c_AW-1:0]  rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 wa_en;
    logic [c_AW-1:0]      wa_addr;
    logic [XLEN-1:0]      wa_data;
    logic                 wb_en;
    logic [c_AW-1:0]      wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 rsv_en;
    logic [c_AW-1:0]      rsv_addr;
    logic                 flush;
    logic                 any_busy;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy, any_busy
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               rsv_en, rsv_addr, flush,
        output rd_data, rd_busy, any_busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : NREGS x XLEN register file with one busy (scoreboard) bit per
//            register, NRD combinational read ports with write bypass, two
//            write ports (B wins on address conflict), a reserve port and a
//            synchronous flush of all busy bits. Register 0 is hard zero.
// Ports    : clk   - clock, all state changes on the rising edge
//            rst_n - asynchronous active-low reset of data and busy bits
//            bus   - regfile_sb_if.slave (reads, writes, reserve, flush,
//                    rd_busy, any_busy)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    regfile_sb_if.slave   bus
);
    localparam int c_AW = $clog2(NREGS);

    // Flattened view of storage; entry 0 is a constant zero.
    logic [XLEN-1:0]  w_rf [NREGS];
    logic [NREGS-1:0] w_busy;

    // ------------------------------------------------------------------
    // Storage: one data register and one busy flop per non-zero address
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign w_rf[i]   = '0;
            assign w_busy[i] = 1'b0;
        end else begin : g_live
            logic [XLEN-1:0] r_q;
            logic            r_b;
            logic            w_wa_hit;
            logic            w_wb_hit;
            logic            w_rsv_hit;

            assign w_wa_hit  = bus.wa_en && (bus.wa_addr == c_AW'(i));
            assign w_wb_hit  = bus.wb_en && (bus.wb_addr == c_AW'(i));
            // A reserve arriving together with flush is discarded.
            assign w_rsv_hit = bus.rsv_en && !bus.flush &&
                               (bus.rsv_addr == c_AW'(i));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                    r_b <= 1'b0;
                end else begin
                    if (w_wb_hit) begin
                        r_q <= bus.wb_data;
                    end else if (w_wa_hit) begin
                        r_q <= bus.wa_data;
                    end
                    // A new producer reserving in the same cycle as the old
                    // producer's write keeps the register busy.
                    if (w_rsv_hit) begin
                        r_b <= 1'b1;
                    end else if (bus.flush || w_wa_hit || w_wb_hit) begin
                        r_b <= 1'b0;
                    end
                end
            end

            assign w_rf[i]   = r_q;
            assign w_busy[i] = r_b;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with same-cycle write bypass
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [c_AW-1:0] w_a;
        logic            w_nz;
        logic            w_wa_hit;
        logic            w_wb_hit;
        logic            w_rsv_hit;
        logic [XLEN-1:0] w_d;

        assign w_a       = bus.rd_addr[k*c_AW +: c_AW];
        assign w_nz      = |w_a;
        assign w_wa_hit  = w_nz && bus.wa_en && (bus.wa_addr == w_a);
        assign w_wb_hit  = w_nz && bus.wb_en && (bus.wb_addr == w_a);
        assign w_rsv_hit = bus.rsv_en && (bus.rsv_addr == w_a);

        always_comb begin
            w_d = w_rf[w_a];
            if (w_wb_hit) begin
                w_d = bus.wb_data;
            end else if (w_wa_hit) begin
                w_d = bus.wa_data;
            end
            // Writes presented while reset is held must not leak through
            // the bypass path.
            if (!rst_n) begin
                w_d = '0;
            end
        end

        assign bus.rd_data[k*XLEN +: XLEN] = w_d;
        // The in-flight write retires the producer unless a new producer
        // reserves the same register in this cycle.
        assign bus.rd_busy[k] = rst_n && w_nz && w_busy[w_a] &&
                                !((w_wa_hit || w_wb_hit) && !w_rsv_hit);
    end

    assign bus.any_busy = |w_busy;

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count, power of two >= 2; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rd_addr  input  NRD*AW  read addresses, port k at bits [k*AW +: AW].
REQ-007 rd_data  output  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
REQ-008 rd_busy  output  NRD  port k register has an outstanding reservation.
REQ-009 wa_en, wa_addr, wa_data  input  1/AW/XLEN  write port A.
REQ-010 wb_en, wb_addr, wb_data  input  1/AW/XLEN  write port B.
REQ-011 rsv_en, rsv_addr  input  1/AW  reserve (mark busy) a destination register.
REQ-012 flush  input  1  synchronous clear of all busy bits.
REQ-013 any_busy  output  1  OR of all busy bits (registered state).

Function
REQ-014 Storage: NREGS x XLEN registers plus one busy bit per register.
REQ-015 Register 0 SHALL read as zero, never be written, never be busy; writes/reserves to address 0 ignored.
REQ-016 Write: on rising edge, enabled port stores data at address (address != 0).
REQ-017 Same-address simultaneous writes A and B: port B value stored; port A dropped.
REQ-018 Read: combinational, zero-latency; rd_data reflects current register contents.
REQ-019 Bypass: if an enabled write targets rd_addr[k] (non-zero) this cycle, rd_data[k] = that write data (B over A on conflict).
REQ-020 Busy set: rsv_en with non-zero address sets that busy bit at next edge.
REQ-021 Busy clear: enabled write to an address clears its busy bit at next edge.
REQ-022 Reserve and write to same address same cycle: busy ends set (new producer wins); data still written.
REQ-023 rd_busy[k] = stored busy bit of rd_addr[k], forced 0 if a write to that address occurs this cycle and no same-cycle reserve to it; 0 for address 0.
REQ-024 flush: all busy bits clear at next edge; a same-cycle rsv_en is ignored; same-cycle writes still update data.
REQ-025 any_busy is derived from stored busy bits only (no same-cycle bypass).
REQ-026 Address >= NREGS cannot occur (power-of-two depth); no out-of-range logic required.

Reset
REQ-027 rst_n low SHALL immediately clear all registers to 0 and all busy bits to 0, independent of clk.
REQ-028 During reset rd_data = 0, rd_busy = 0, any_busy = 0 for all ports; writes, reserves, flush ignored.
REQ-029 Reset asserted mid-operation discards pending writes/reservations; first write accepted on first rising edge after rst_n deasserts.

Verification
REQ-030 Reset then write A x5=0xDEADBEEF, read port 0 x5 next cycle -> 0xDEADBEEF, rd_busy[0]=0.
REQ-031 Same cycle wa x7=0x11, wb x7=0x22, read x7 -> bypass 0x22 that cycle, stored 0x22 after edge.
REQ-032 Write x0=0xFFFFFFFF with rsv x0 -> rd_data x0 = 0, rd_busy 0, any_busy 0.
REQ-033 rsv x3; next cycle rd_busy x3=1, any_busy=1; write x3=0x5 -> rd_busy=0 and rd_data=0x5 same cycle, busy bit cleared after edge.
REQ-034 Reserve x4,x9 over two cycles; flush with rsv x12 -> after edge any_busy=0, x12 not busy.
REQ-035 Load x2=0xA5A5A5A5, reserve x2, pulse rst_n low between edges -> rd_data x2=0 and any_busy=0 immediately.
